led_display_ctrl: RTL and testbench



---
 rtl/led_pkg.sv | 18 +
 rtl/led_display_ctrl_tick_gen.sv | 28 ++
 rtl/led_display_ctrl.sv | 117 +++++++++++
 tb/tb_led_display_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared mode codes and small types for the tug-of-war LED bank driver.
package led_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] LED_ALL   = 3'd0;
  localparam logic [MODE_W-1:0] LED_NONE  = 3'd1;
  localparam logic [MODE_W-1:0] LED_BLINK = 3'd2;
  localparam logic [MODE_W-1:0] LED_SCORE = 3'd3;
  localparam logic [MODE_W-1:0] LED_CHASE = 3'd4;
  localparam logic [MODE_W-1:0] LED_FLASH = 3'd5;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_display_ctrl_tick_gen.sv
// Animation frame prescaler: tick on the last cycle of each TICK_DIV-cycle frame.
module tick_gen #(
  parameter int TICK_DIV = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // clear wins over the wrap so a restarted frame gets its full length.
  always_comb begin
    tick  = (cnt_q == LAST) && !clear;
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_display_ctrl.sv
// Registered LED bank driver: static modes plus tick-paced blink, chase and flash animations.
module led_display_ctrl
  import led_pkg::*;
#(
  parameter int NUM_LEDS    = 7,
  parameter int TICK_DIV    = 2500000,
  parameter int FLASH_COUNT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MODE_W-1:0]   mode,
  input  logic [NUM_LEDS-1:0] score,
  output logic [NUM_LEDS-1:0] leds_out,
  output logic                flash_done
);

  localparam int PW = $clog2(NUM_LEDS);
  localparam int FW = $clog2(2 * FLASH_COUNT) + 1;
  localparam logic [PW-1:0] POS_LAST   = PW'(NUM_LEDS - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_COUNT - 1);

  logic [MODE_W-1:0]   mode_q, mode_d;
  logic                phase_q, phase_d;
  logic [PW-1:0]       pos_q, pos_d;
  dir_e                dir_q, dir_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic                fin_q, fin_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                done_q, done_d;
  logic                restart;
  logic                tick;

  assign restart = (mode != mode_q);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (restart),
    .tick  (tick)
  );

  always_comb begin
    mode_d  = mode;
    phase_d = phase_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    fcnt_d  = fcnt_q;
    fin_d   = fin_q;
    done_d  = 1'b0;
    leds_d  = '0;

    if (restart) begin
      phase_d = 1'b0;
      pos_d   = '0;
      dir_d   = DIR_UP;
      fcnt_d  = '0;
      fin_d   = 1'b0;
    end else if (tick) begin
      case (mode)
        LED_BLINK: phase_d = ~phase_q;
        LED_CHASE: begin
          pos_d = (dir_q == DIR_UP) ? pos_q + 1'b1 : pos_q - 1'b1;
          // Turn around on arrival so the end LED is shown for one frame only.
          if (pos_d == POS_LAST)  dir_d = DIR_DOWN;
          else if (pos_d == '0)   dir_d = DIR_UP;
        end
        LED_FLASH: begin
          if (!fin_q) begin
            if (fcnt_q == FLASH_LAST) begin
              fin_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    // Frame is built from the next state so a new frame appears with its tick.
    case (mode)
      LED_ALL:   leds_d = '1;
      LED_SCORE: leds_d = score;
      LED_BLINK: leds_d = phase_d ? '0 : score;
      LED_CHASE: leds_d = NUM_LEDS'(1) << pos_d;
      LED_FLASH: leds_d = (fin_d || fcnt_d[0]) ? '0 : '1;
      default:   leds_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= LED_NONE;
      phase_q <= 1'b0;
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      fcnt_q  <= '0;
      fin_q   <= 1'b0;
      leds_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      fcnt_q  <= fcnt_d;
      fin_q   <= fin_d;
      leds_q  <= leds_d;
      done_q  <= done_d;
    end
  end

  assign leds_out   = leds_q;
  assign flash_done = done_q;

endmodule

// File: tb/tb_led_display_ctrl.sv
// Bench for led_display_ctrl: closed-form frame model checked every cycle, plus directed literal checks.
module tb_led_display_ctrl;

  localparam int N  = 7;
  localparam int TD = 4;
  localparam int FC = 2;

  logic         clk;
  logic         rst;
  logic [2:0]   mode;
  logic [N-1:0] score;
  logic [N-1:0] leds_out;
  logic         flash_done;

  int total = 0;
  int bad   = 0;

  led_display_ctrl #(
    .NUM_LEDS    (N),
    .TICK_DIV    (TD),
    .FLASH_COUNT (FC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .score      (score),
    .leds_out   (leds_out),
    .flash_done (flash_done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // k = edges since the last restart; frame number = k / TD.
  logic [2:0]   m_mode_q;
  int           m_k;
  logic         model_valid = 1'b0;
  logic [N-1:0] exp_leds;
  logic         exp_done;

  function automatic void frame_of(input logic [2:0] m, input int k, input logic [N-1:0] sc,
                                   output logic [N-1:0] l, output logic d);
    int f;
    int p;
    f = k / TD;
    l = '0;
    d = 1'b0;
    case (m)
      3'd0: l = '1;
      3'd2: l = (f % 2 == 0) ? sc : '0;
      3'd3: l = sc;
      3'd4: begin
        p = f % (2 * N - 2);
        if (p >= N) p = 2 * N - 2 - p;
        l = N'(1 << p);
      end
      3'd5: begin
        l = (f < 2 * FC && f % 2 == 0) ? '1 : '0;
        d = (k == 2 * FC * TD);
      end
      default: l = '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode_q    = 3'd1;
      m_k         = 0;
      exp_leds    = '0;
      exp_done    = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (mode != m_mode_q) begin
        m_k      = 0;
        m_mode_q = mode;
      end else begin
        m_k++;
      end
      frame_of(mode, m_k, score, exp_leds, exp_done);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      total++;
      if (leds_out !== exp_leds || flash_done !== exp_done) begin
        bad++;
        $display("FAIL model_cmp t=%0t leds=%b done=%b expected leds=%b done=%b",
                 $time, leds_out, flash_done, exp_leds, exp_done);
      end
    end
  end

  // ---------------- driver / literal checks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [N-1:0] exp_l, input logic exp_d);
    total++;
    if (leds_out !== exp_l || flash_done !== exp_d) begin
      bad++;
      $display("FAIL %s leds=%b done=%b expected leds=%b done=%b",
               nm, leds_out, flash_done, exp_l, exp_d);
    end
  endtask

  initial begin
    rst   = 1'b1;
    mode  = 3'd0;
    score = '0;

    step(1); chk("reset_1", 7'b0000000, 1'b0);
    step(1); chk("reset_2", 7'b0000000, 1'b0);
    rst = 1'b0;
    step(1); chk("all_after_reset", 7'b1111111, 1'b0);

    mode = 3'd3; score = 7'b0010110;
    step(1); chk("score_a", 7'b0010110, 1'b0);
    score = 7'b0001000;
    step(1); chk("score_b", 7'b0001000, 1'b0);

    mode = 3'd2; score = 7'b1010101;
    step(1); chk("blink_k0", 7'b1010101, 1'b0);
    step(3); chk("blink_k3", 7'b1010101, 1'b0);
    step(1); chk("blink_k4_off", 7'b0000000, 1'b0);
    step(4); chk("blink_k8_on", 7'b1010101, 1'b0);
    score = 7'b0000011;
    step(1); chk("blink_live_score", 7'b0000011, 1'b0);
    step(7); chk("blink_k16_on", 7'b0000011, 1'b0);

    mode = 3'd6;
    step(1); chk("mode6_none", 7'b0000000, 1'b0);

    mode = 3'd4;
    step(1);  chk("chase_k0", 7'b0000001, 1'b0);
    step(24); chk("chase_end_first", 7'b1000000, 1'b0);
    step(3);  chk("chase_end_last", 7'b1000000, 1'b0);
    step(1);  chk("chase_bounce", 7'b0100000, 1'b0);
    step(20); chk("chase_wrap", 7'b0000001, 1'b0);

    rst = 1'b1;
    step(1); chk("mid_reset", 7'b0000000, 1'b0);
    rst = 1'b0;
    step(1); chk("chase_after_reset", 7'b0000001, 1'b0);

    step(15); chk("chase_pos3", 7'b0001000, 1'b0);
    mode = 3'd2;
    step(1); chk("restart_prio_on", 7'b0000011, 1'b0);
    step(3); chk("restart_prio_hold", 7'b0000011, 1'b0);
    step(1); chk("restart_prio_off", 7'b0000000, 1'b0);

    mode = 3'd5;
    step(1);  chk("flash_on0", 7'b1111111, 1'b0);
    step(4);  chk("flash_off0", 7'b0000000, 1'b0);
    step(4);  chk("flash_on1", 7'b1111111, 1'b0);
    step(7);  chk("flash_pre_done", 7'b0000000, 1'b0);
    step(1);  chk("flash_done_1", 7'b0000000, 1'b1);
    step(1);  chk("flash_after_done", 7'b0000000, 1'b0);
    step(12); chk("flash_hold", 7'b0000000, 1'b0);

    mode = 3'd1;
    step(1); chk("none_between", 7'b0000000, 1'b0);
    mode = 3'd5;
    step(1);  chk("flash2_on0", 7'b1111111, 1'b0);
    step(15); chk("flash2_pre_done", 7'b0000000, 1'b0);
    step(1);  chk("flash_done_2", 7'b0000000, 1'b1);
    step(2);  chk("flash2_after", 7'b0000000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
